systolic_array_nxn: RTL and testbench
=====================================

// Module: systolic_array_nxn
// PURPOSE
//  Parametrised NxN output-stationary int MAC array computing C = A*B, A: NxK, B: KxN, K set per job.
//  Successor of the fixed 4x4 array. Adds internal input skew, valid/ready streaming, job FSM,
//  accumulator clear and result hold. Sits between the operand buffers and the writeback unit.
// PARAMETERS
//  N      4   array dimension (rows = cols), 2..16
//  DW     8   signed operand width
//  AW     32  signed accumulator width, >= 2*DW + clog2(KMAX)
//  KMAX   256 max reduction depth per job
// PORTS
//  clk       in   1        single clock
//  rst       in   1        synchronous, active-high reset
//  start     in   1        job start pulse, accepted only in IDLE
//  k_len     in   clog2(KMAX+1)  reduction depth K, sampled with start; 0 is treated as 1
//  in_valid  in   1        a_col/b_row beat valid
//  in_ready  out  1        beat accepted when in_valid && in_ready
//  a_col     in   N*DW     A[i][k] for i=0..N-1, lane i at [i*DW +: DW]
//  b_row     in   N*DW     B[k][j] for j=0..N-1, lane j at [j*DW +: DW]
//  busy      out  1        high from accepted start until done
//  done      out  1        one-cycle pulse, results valid from this cycle
//  c_out     out  N*N*AW   C[i][j] at [(i*N+j)*AW +: AW], held until next accepted start
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=0, busy=0, done=0, c_out=0, all skew/PE regs=0, beat count=0.
//  FSM IDLE -> STREAM on start. STREAM -> DRAIN after beat k_len-1 accepted.
//  DRAIN -> DONE after 2N-2 cycles. DONE -> IDLE after 1 cycle.
//  Accepted start clears all PE accumulators and skew regs in the same cycle. c_out goes 0.
//  start outside IDLE is ignored. in_valid outside STREAM is ignored.
//  in_ready = (state==STREAM). No backpressure beyond that.
//  Skew: lane i of a_col delayed by i regs into row i; lane j of b_row delayed by j regs into col j.
//  PE(i,j): registers a (to right) and b (down), acc <= acc + a*b.
//  Product is full 2*DW signed, sign-extended to AW; add wraps mod 2^AW (no saturation).
//  Stall cycles in STREAM (in_valid=0) inject zeros into skew line 0. Result unaffected.
//  done asserted exactly 2N-1 cycles after the last-beat acceptance cycle. busy falls with done.
//  c_out = PE accumulators, continuously; stable after done until next start.
//  Back-to-back: start in the cycle after done is accepted (state is IDLE).
//  rst mid-job aborts: all state returns to reset values next cycle, no done pulse.
// STRUCTURE
//  Shared package systolic_pkg: state enum {IDLE,STREAM,DRAIN,DONE}, default DW/AW, clog2 helper.
//  Sub-module pe_acc: one PE with sync clear; ports clk, rst, clr, a_in, b_in, a_out, b_out, acc.
//  Top holds the FSM, beat/drain counters, skew shift-register triangles, and a generate-loop PE grid.
// TESTING (N=4, DW=8, AW=32 unless noted)
//  1 Identity: A=I4, B[k][j]=4k+j+1, K=4 -> c_out==B; done exactly 7 cycles after last beat.
//  2 Extremes: all A=-128, all B=-128, K=256 -> every C = 4194304; A=-128, B=127, K=4 -> -65024.
//  3 Stalls: same job as 1, in_valid toggled 1-0-0-1-... -> identical c_out; in_ready=0 outside STREAM.
//  4 Back-to-back: job (A=all 1, B=all 2, K=3 -> C=6), start the cycle after done, then all-1s K=1 -> C=1.
//    c_out reads 0 the cycle after second start.
//  5 Ignored start and k_len=0: start pulsed in STREAM has no effect; k_len=0 runs as K=1.
//  6 Reset abort: rst during DRAIN -> next cycle busy=0, c_out=0, no done pulse. N=2 and N=8 random vs model.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the NxN systolic MAC array.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int DEF_DW = 8;
   localparam int DEF_AW = 32;

   // Ceiling log2 for sizing counters from parameters; clog2(1) = 0.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/systolic_array_nxn_pe_acc.sv
// One output-stationary PE: forwards a right and b down, accumulates a*b.
// Latency: 1 cycle for forwarding and for the accumulator update.
// Backpressure: none; updates every cycle, zeros act as bubbles.
module pe_acc
   import systolic_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int AW = DEF_AW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic signed [DW-1:0] a_in,
   input  logic signed [DW-1:0] b_in,
   output logic signed [DW-1:0] a_out,
   output logic signed [DW-1:0] b_out,
   output logic signed [AW-1:0] acc
);

   logic signed [2*DW-1:0] prod;
   logic signed [AW-1:0]   prod_ext;

   assign prod     = a_in * b_in;
   assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};

   // Operand forwarding and wrapping accumulate; clr starts a fresh job.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/systolic_array_nxn.sv
// NxN output-stationary int MAC array computing C = A*B with K set per job.
// Latency: done 2N-1 cycles after the last accepted beat; c_out held until next start.
// Backpressure: in_ready only while streaming; stall cycles inject zero bubbles.
module systolic_array_nxn
   import systolic_pkg::*;
#(
   parameter int N    = 4,
   parameter int DW   = DEF_DW,
   parameter int AW   = DEF_AW,
   parameter int KMAX = 256,
   localparam int KW  = clog2(KMAX + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [KW-1:0]         k_len,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DW-1:0]       a_col,
   input  logic [N*DW-1:0]       b_row,
   output logic                  busy,
   output logic                  done,
   output logic [N*N*AW-1:0]     c_out
);

   localparam int DCW = clog2(2 * N);

   state_t          state_q;
   state_t          state_d;
   logic [KW-1:0]   beat_cnt;
   logic [KW-1:0]   k_last;
   logic [DCW-1:0]  drain_cnt;
   logic            start_acc;
   logic            beat_acc;
   logic            last_beat;
   logic            clr;

   assign start_acc = start && (state_q == IDLE);
   assign beat_acc  = in_valid && (state_q == STREAM);
   assign last_beat = (beat_cnt == k_last);
   assign clr       = start_acc;

   assign in_ready  = (state_q == STREAM);
   assign busy      = (state_q == STREAM) || (state_q == DRAIN);
   assign done      = (state_q == DONE);

   // Next-state: drain lasts 2N-2 cycles so the far corner PE sees its last beat.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = STREAM;
         STREAM:  if (beat_acc && last_beat) state_d = DRAIN;
         DRAIN:   if (drain_cnt == DCW'(2 * N - 3)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register plus beat and drain counters; k_len of 0 runs as 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         beat_cnt  <= '0;
         k_last    <= '0;
         drain_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            beat_cnt <= '0;
            k_last   <= (k_len == '0) ? '0 : (k_len - KW'(1));
         end else if (beat_acc) begin
            beat_cnt <= beat_cnt + KW'(1);
         end
         if (state_q == DRAIN) drain_cnt <= drain_cnt + DCW'(1);
         else                  drain_cnt <= '0;
      end
   end

   // Skewed operands entering row i / column j of the grid.
   logic signed [DW-1:0] a_lane [N];
   logic signed [DW-1:0] b_lane [N];

   for (genvar i = 0; i < N; i++) begin : g_skew
      logic signed [DW-1:0] a_src;
      logic signed [DW-1:0] b_src;

      assign a_src = beat_acc ? a_col[i*DW +: DW] : '0;
      assign b_src = beat_acc ? b_row[i*DW +: DW] : '0;

      if (i == 0) begin : g_direct
         assign a_lane[i] = a_src;
         assign b_lane[i] = b_src;
      end else begin : g_sr
         logic signed [DW-1:0] a_sr [i];
         logic signed [DW-1:0] b_sr [i];

         // Lane i delayed by i stages so row/column wavefronts meet on the diagonal.
         always_ff @(posedge clk) begin
            if (rst || clr) begin
               for (int s = 0; s < i; s++) begin
                  a_sr[s] <= '0;
                  b_sr[s] <= '0;
               end
            end else begin
               a_sr[0] <= a_src;
               b_sr[0] <= b_src;
               for (int s = 1; s < i; s++) begin
                  a_sr[s] <= a_sr[s-1];
                  b_sr[s] <= b_sr[s-1];
               end
            end
         end

         assign a_lane[i] = a_sr[i-1];
         assign b_lane[i] = b_sr[i-1];
      end
   end

   // a_h[i][j] is the a operand entering PE(i,j) from the left, b_v from above.
   logic signed [DW-1:0] a_h [N][N];
   logic signed [DW-1:0] b_v [N][N];
   logic signed [DW-1:0] a_edge_unused [N];
   logic signed [DW-1:0] b_edge_unused [N];

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic signed [DW-1:0] a_o;
         logic signed [DW-1:0] b_o;
         logic signed [AW-1:0] acc_o;

         if (j == 0) begin : g_a_src
            assign a_h[i][0] = a_lane[i];
         end
         if (i == 0) begin : g_b_src
            assign b_v[0][j] = b_lane[j];
         end

         pe_acc #(
            .DW (DW),
            .AW (AW)
         ) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .a_in  (a_h[i][j]),
            .b_in  (b_v[i][j]),
            .a_out (a_o),
            .b_out (b_o),
            .acc   (acc_o)
         );

         if (j < N - 1) begin : g_a_fwd
            assign a_h[i][j+1] = a_o;
         end else begin : g_a_edge
            assign a_edge_unused[i] = a_o;
         end
         if (i < N - 1) begin : g_b_fwd
            assign b_v[i+1][j] = b_o;
         end else begin : g_b_edge
            assign b_edge_unused[j] = b_o;
         end

         assign c_out[(i*N+j)*AW +: AW] = acc_o;
      end
   end

endmodule

// File: tb/tb_systolic_array_nxn.sv
module tb_systolic_array_nxn;

   localparam int N  = 4;
   localparam int N2 = 2;
   localparam int DW = 8;
   localparam int AW = 32;
   localparam int KW = 9;

   localparam int C_ID   = 0;
   localparam int C_M128 = 1;
   localparam int C_P127 = 2;
   localparam int C_ONE  = 3;
   localparam int C_TWO  = 4;
   localparam int C_PAT  = 5;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [KW-1:0]        k_len;
   logic                 in_valid;
   logic                 in_ready;
   logic [N*DW-1:0]      a_col;
   logic [N*DW-1:0]      b_row;
   logic                 busy;
   logic                 done;
   logic [N*N*AW-1:0]    c_out;

   logic                 start2;
   logic [KW-1:0]        k_len2;
   logic                 in_valid2;
   logic                 in_ready2;
   logic [N2*DW-1:0]     a_col2;
   logic [N2*DW-1:0]     b_row2;
   logic                 busy2;
   logic                 done2;
   logic [N2*N2*AW-1:0]  c_out2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   systolic_array_nxn #(.N(N), .DW(DW), .AW(AW), .KMAX(256)) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
      .busy(busy), .done(done), .c_out(c_out)
   );

   systolic_array_nxn #(.N(N2), .DW(DW), .AW(AW), .KMAX(256)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .k_len(k_len2),
      .in_valid(in_valid2), .in_ready(in_ready2), .a_col(a_col2), .b_row(b_row2),
      .busy(busy2), .done(done2), .c_out(c_out2)
   );

   typedef struct {
      int k;
      int ac;
      int bc;
      bit stall;
      bit exp_pat;   // 1: expect C[i][j] = 4i+j+1, else every C = exp_c
      int exp_c;
   } vec_t;

   vec_t vt [6];

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] val(input int code, input int r, input int c);
      int v;
      case (code)
         C_ID:    v = (r == c) ? 1 : 0;
         C_M128:  v = -128;
         C_P127:  v = 127;
         C_ONE:   v = 1;
         C_TWO:   v = 2;
         default: v = 4 * r + c + 1;
      endcase
      return v[7:0];
   endfunction

   task automatic check_c(input string tag, input bit pat, input int uni);
      int cv;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            cv = c_out[(i*N+j)*AW +: AW];
            check($sformatf("%s_c%0d%0d", tag, i, j), cv, pat ? (4*i+j+1) : uni);
         end
      end
   endtask

   // Starts a job in the current cycle, streams K beats, waits for done.
   task automatic run_job(input string tag, input int kl, input int ac, input int bc,
                          input bit stall, input bit poke, output int lat);
      int keff, beat, cyc, ph;
      bit v, acc;
      start = 1'b1;
      k_len = kl[KW-1:0];
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_start"}, busy, 1);
      check({tag, "_cout_clr"}, |c_out, 0);
      keff = (kl == 0) ? 1 : kl;
      beat = 0; cyc = 0; ph = 0;
      while (beat < keff && cyc < 3000) begin
         v = stall ? ((ph % 3) == 0) : 1'b1;
         ph++;
         in_valid = v;
         for (int i = 0; i < N; i++) begin
            a_col[i*DW +: DW] = v ? val(ac, i, beat) : 8'h55;
            b_row[i*DW +: DW] = v ? val(bc, beat, i) : 8'h55;
         end
         if (poke && beat == 1) begin
            start = 1'b1;
            k_len = 9'd1;
         end
         acc = v && in_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc) beat++;
         cyc++;
      end
      in_valid = 1'b0;
      check({tag, "_ready_drain"}, in_ready, 0);
      lat = 1;
      while (!done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_busy_at_done"}, busy, 0);
   endtask

   int lat;
   int a2 [N2][16];
   int b2 [16][N2];
   int ce [N2*N2];
   bit seen;

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; a_col = '0; b_row = '0;
      start2 = 1'b0; k_len2 = '0; in_valid2 = 1'b0; a_col2 = '0; b_row2 = '0;

      vt[0] = '{4,   C_ID,   C_PAT,  1'b0, 1'b1, 0};
      vt[1] = '{4,   C_ID,   C_PAT,  1'b1, 1'b1, 0};
      vt[2] = '{256, C_M128, C_M128, 1'b0, 1'b0, 4194304};
      vt[3] = '{4,   C_M128, C_P127, 1'b0, 1'b0, -65024};
      vt[4] = '{3,   C_ONE,  C_TWO,  1'b0, 1'b0, 6};
      vt[5] = '{0,   C_ONE,  C_ONE,  1'b0, 1'b0, 1};

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cout", |c_out, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table: each job starts in the cycle right after the previous done.
      for (int v = 0; v < 6; v++) begin
         run_job($sformatf("v%0d", v), vt[v].k, vt[v].ac, vt[v].bc, vt[v].stall, 1'b0, lat);
         check($sformatf("v%0d_done_lat", v), lat, 7);
         check_c($sformatf("v%0d", v), vt[v].exp_pat, vt[v].exp_c);
         @(posedge clk); #1;
         check($sformatf("v%0d_done_pulse", v), done, 0);
         check($sformatf("v%0d_idle_ready", v), in_ready, 0);
         check($sformatf("v%0d_hold_c00", v), $signed(c_out[AW-1:0]), vt[v].exp_pat ? 1 : vt[v].exp_c);
      end

      // start pulsed mid-stream with k_len=1 must not shorten or restart the job
      run_job("poke", 4, C_ID, C_PAT, 1'b0, 1'b1, lat);
      check("poke_done_lat", lat, 7);
      check_c("poke", 1'b1, 0);
      @(posedge clk); #1;

      // Reset during DRAIN aborts the job with no done pulse
      start = 1'b1; k_len = 9'd2;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
         a_col[i*DW +: DW] = 8'd1;
         b_row[i*DW +: DW] = 8'd1;
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_busy_pre", busy, 1);
      check("abort_cout_pre", |c_out, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_cout", |c_out, 0);
      check("abort_ready", in_ready, 0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check("abort_no_done", seen, 0);

      // N=2 instance: random operands against a reference product
      for (int job = 0; job < 2; job++) begin
         int kk, s, t;
         kk = 3 + job * 4;
         for (int k = 0; k < kk; k++) begin
            for (int i = 0; i < N2; i++) begin
               a2[i][k] = int'($urandom_range(0, 255)) - 128;
               b2[k][i] = int'($urandom_range(0, 255)) - 128;
            end
         end
         for (int i = 0; i < N2; i++) begin
            for (int j = 0; j < N2; j++) begin
               s = 0;
               for (int k = 0; k < kk; k++) s += a2[i][k] * b2[k][j];
               ce[i*N2+j] = s;
            end
         end
         start2 = 1'b1; k_len2 = kk[KW-1:0];
         @(posedge clk); #1;
         start2 = 1'b0;
         for (int k = 0; k < kk; k++) begin
            in_valid2 = 1'b1;
            for (int i = 0; i < N2; i++) begin
               t = a2[i][k];
               a_col2[i*DW +: DW] = t[7:0];
               t = b2[k][i];
               b_row2[i*DW +: DW] = t[7:0];
            end
            @(posedge clk); #1;
         end
         in_valid2 = 1'b0;
         lat = 1;
         while (!done2 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
         end
         check($sformatf("n2_j%0d_done_lat", job), lat, 3);
         for (int e = 0; e < N2*N2; e++) begin
            s = c_out2[e*AW +: AW];
            check($sformatf("n2_j%0d_c%0d", job, e), s, ce[e]);
         end
         @(posedge clk); #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
